// File: rtl/cpu8_pkg.sv
// Shared encodings for the 8-bit CPU front end: opcodes, fetch states and
// predecode classes. The IR decoder takes its encodings from here too.
package cpu8_pkg;

  localparam logic [7:0] OPC_LD_A   = 8'h90;
  localparam logic [7:0] OPC_LD_B   = 8'h91;
  localparam logic [7:0] OPC_ST     = 8'hC0;
  localparam logic [7:0] OPC_JMP    = 8'hC1;
  localparam logic [7:0] OPC_HALT   = 8'hFF;
  localparam logic [7:0] OPC_ALU_LO = 8'h92;
  localparam logic [7:0] OPC_ALU_HI = 8'hA9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_OFETCH,
    ST_OLOAD,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    CLS_OPND,
    CLS_SINGLE,
    CLS_HALT,
    CLS_ILLEGAL
  } opc_class_e;

endpackage

// File: rtl/opc_predecode.sv
// Combinational opcode byte classifier used by the fetch sequencer in LOAD.
module opc_predecode
  import cpu8_pkg::*;
(
  input  logic [7:0] opc,
  output logic [1:0] cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opc == OPC_LD_A || opc == OPC_LD_B || opc == OPC_ST || opc == OPC_JMP)
      cls = CLS_OPND;
    else if (opc >= OPC_ALU_LO && opc <= OPC_ALU_HI)
      cls = CLS_SINGLE;
    else if (opc == OPC_HALT)
      cls = CLS_HALT;
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: walks the PC over program memory, strobes
// opcodes into the IR, fetches LD/ST/JMP operands and waits on the datapath.
module fetch_seq
  import cpu8_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       CLK,
  input  logic       CLRn,
  input  logic       RUN,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_RDn,
  input  logic [7:0] MEM_D,
  output logic [7:0] IR_D,
  output logic       IIRn,
  output logic [7:0] OPND,
  output logic       OPND_VLD,
  input  logic       EXEC_DONE,
  output logic       HALTED,
  output logic       ILLEGAL
);

  state_e     state;
  logic [7:0] pc;
  logic [7:0] opc_q;
  logic [1:0] cls_raw;
  opc_class_e cls;

  opc_predecode u_predecode (
    .opc (MEM_D),
    .cls (cls_raw)
  );

  assign cls      = opc_class_e'(cls_raw);
  assign MEM_ADDR = pc;
  assign IR_D     = MEM_D;

  // Strobe outputs are registered alongside the next state, so each one is
  // a flop output that tracks the state it belongs to with no decode glitch.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state    <= ST_IDLE;
      pc       <= PC_RESET;
      opc_q    <= 8'h00;
      OPND     <= 8'h00;
      MEM_RDn  <= 1'b1;
      IIRn     <= 1'b1;
      OPND_VLD <= 1'b0;
      HALTED   <= 1'b0;
      ILLEGAL  <= 1'b0;
    end else begin
      MEM_RDn  <= 1'b1;
      IIRn     <= 1'b1;
      OPND_VLD <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (RUN) begin
            state   <= ST_FETCH;
            MEM_RDn <= 1'b0;
          end
        end
        ST_FETCH: begin
          state <= ST_LOAD;
          IIRn  <= 1'b0;
        end
        ST_LOAD: begin
          opc_q <= MEM_D;
          pc    <= pc + 8'd1;
          case (cls)
            CLS_OPND: begin
              state   <= ST_OFETCH;
              MEM_RDn <= 1'b0;
            end
            CLS_SINGLE: state <= ST_EXEC;
            CLS_HALT: begin
              state  <= ST_HALT;
              HALTED <= 1'b1;
            end
            default: begin
              state   <= ST_HALT;
              HALTED  <= 1'b1;
              ILLEGAL <= 1'b1;
            end
          endcase
        end
        ST_OFETCH: state <= ST_OLOAD;
        ST_OLOAD: begin
          OPND <= MEM_D;
          if (opc_q == OPC_JMP) begin
            pc      <= MEM_D;
            state   <= ST_FETCH;
            MEM_RDn <= 1'b0;
          end else begin
            // only LD_A/LD_B/ST reach here, all of which carry data to EXEC
            pc       <= pc + 8'd1;
            state    <= ST_EXEC;
            OPND_VLD <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (EXEC_DONE) begin
            state   <= ST_FETCH;
            MEM_RDn <= 1'b0;
          end else begin
            OPND_VLD <= OPND_VLD;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: two instances (PC_RESET 00 and FE) run directed and
// random programs against an instruction-level trace model.
module tb_fetch_seq;

  localparam int LIM = 160;

  typedef struct packed {
    logic       rdn, iirn, vld, halted, illegal;
    logic [7:0] addr, ir, opnd;
  } cyc_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic CLRn = 1'b0, RUN = 1'b0, EXEC_DONE = 1'b0;
  logic [7:0] mem [2][256];
  logic [7:0] md0 = 8'h00, md1 = 8'h00;
  logic [7:0] addr0, addr1, ir0, ir1, opnd0, opnd1;
  logic rdn0, rdn1, iirn0, iirn1, vld0, vld1, hlt0, hlt1, ill0, ill1;

  fetch_seq #(.PC_RESET(8'h00)) dut0 (
    .CLK(CLK), .CLRn(CLRn), .RUN(RUN), .MEM_ADDR(addr0), .MEM_RDn(rdn0),
    .MEM_D(md0), .IR_D(ir0), .IIRn(iirn0), .OPND(opnd0), .OPND_VLD(vld0),
    .EXEC_DONE(EXEC_DONE), .HALTED(hlt0), .ILLEGAL(ill0));

  fetch_seq #(.PC_RESET(8'hFE)) dut1 (
    .CLK(CLK), .CLRn(CLRn), .RUN(RUN), .MEM_ADDR(addr1), .MEM_RDn(rdn1),
    .MEM_D(md1), .IR_D(ir1), .IIRn(iirn1), .OPND(opnd1), .OPND_VLD(vld1),
    .EXEC_DONE(EXEC_DONE), .HALTED(hlt1), .ILLEGAL(ill1));

  // synchronous program memory: data appears the cycle after the read request
  always @(posedge CLK) begin
    if (!rdn0) md0 <= mem[0][addr0];
    if (!rdn1) md1 <= mem[1][addr1];
  end

  cyc_t tr  [2][LIM];
  cyc_t act [2][LIM];
  bit   run_seq  [LIM];
  bit   done_seq [LIM];
  int   n_chk = 0, n_pass = 0;

  function automatic cyc_t mk(logic rdn, logic iirn, logic vld, logic [7:0] addr,
                              logic [7:0] ir, logic [7:0] opnd, logic halted, logic illegal);
    cyc_t e;
    e.rdn = rdn; e.iirn = iirn; e.vld = vld; e.addr = addr;
    e.ir = ir; e.opnd = opnd; e.halted = halted; e.illegal = illegal;
    return e;
  endfunction

  function automatic cyc_t cur(int i);
    if (i == 0) return mk(rdn0, iirn0, vld0, addr0, ir0, opnd0, hlt0, ill0);
    return mk(rdn1, iirn1, vld1, addr1, ir1, opnd1, hlt1, ill1);
  endfunction

  task automatic put(input int i, inout int c, input cyc_t e);
    if (c < LIM) tr[i][c] = e;
    c++;
  endtask

  // Expected per-cycle outputs from instruction semantics: each instruction
  // contributes its fixed fetch/load/operand cycles plus EXEC cycles until done.
  task automatic build_trace(input int i, input logic [7:0] pc0);
    int c = 0;
    logic [7:0] pc = pc0, opnd = 8'h00, op = 8'h00, ov;
    bit hlt = 0, ill = 0, has_exec, dvld, d;
    while (c < LIM && !run_seq[c]) put(i, c, mk(1, 1, 0, pc, op, opnd, 0, 0));
    put(i, c, mk(1, 1, 0, pc, op, opnd, 0, 0));
    while (c < LIM && !hlt) begin
      put(i, c, mk(0, 1, 0, pc, op, opnd, 0, 0));
      op = mem[i][pc];
      put(i, c, mk(1, 0, 0, pc, op, opnd, 0, 0));
      pc = pc + 8'd1;
      has_exec = 0; dvld = 0;
      if (op == 8'h90 || op == 8'h91 || op == 8'hC0 || op == 8'hC1) begin
        put(i, c, mk(0, 1, 0, pc, op, opnd, 0, 0));
        ov = mem[i][pc];
        put(i, c, mk(1, 1, 0, pc, op, opnd, 0, 0));
        pc = pc + 8'd1;
        opnd = ov;
        if (op == 8'hC1) pc = ov;
        else begin has_exec = 1; dvld = 1; end
      end else if (op >= 8'h92 && op <= 8'hA9) begin
        has_exec = 1;
      end else begin
        hlt = 1;
        ill = (op != 8'hFF);
      end
      if (has_exec) begin
        do begin
          d = (c < LIM) ? done_seq[c] : 1'b1;
          put(i, c, mk(1, 1, dvld, pc, op, opnd, 0, 0));
        end while (!d);
      end
    end
    while (c < LIM) put(i, c, mk(1, 1, 0, pc, op, opnd, 1, ill));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic cmp_cycle(input int i, input int c);
    cyc_t e = tr[i][c], a = act[i][c];
    bit ok;
    ok = (a.rdn === e.rdn) && (a.iirn === e.iirn) && (a.vld === e.vld) &&
         (a.addr === e.addr) && (a.opnd === e.opnd) && (a.halted === e.halted) &&
         (a.illegal === e.illegal) && (e.iirn || a.ir === e.ir);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL cycle inst%0d c%0d: got rdn%b iirn%b vld%b addr%h ir%h opnd%h h%b i%b expected rdn%b iirn%b vld%b addr%h ir%h opnd%h h%b i%b",
                  i, c, a.rdn, a.iirn, a.vld, a.addr, a.ir, a.opnd, a.halted, a.illegal,
                  e.rdn, e.iirn, e.vld, e.addr, e.ir, e.opnd, e.halted, e.illegal);
  endtask

  task automatic run_test(input int abort_at);
    CLRn = 1'b0; RUN = 1'b0; EXEC_DONE = 1'b0;
    build_trace(0, 8'h00);
    build_trace(1, 8'hFE);
    @(negedge CLK); @(negedge CLK);
    CLRn = 1'b1;
    for (int c = 0; c < LIM; c++) begin
      RUN = run_seq[c]; EXEC_DONE = done_seq[c];
      #1;
      act[0][c] = cur(0); act[1][c] = cur(1);
      cmp_cycle(0, c); cmp_cycle(1, c);
      if (c == abort_at) begin
        #1 CLRn = 1'b0;
        #1;
        chk("abort rdn",    {rdn1, rdn0},   2'b11);
        chk("abort iirn",   {iirn1, iirn0}, 2'b11);
        chk("abort vld",    {vld1, vld0},   2'b00);
        chk("abort opnd",   {opnd1, opnd0}, 16'h0000);
        chk("abort status", {hlt1, ill1, hlt0, ill0}, 4'b0000);
        chk("abort addr",   {addr1, addr0}, 16'hFE00);
        return;
      end
      @(negedge CLK);
    end
  endtask

  task automatic fill(input int i, input logic [7:0] v);
    for (int a = 0; a < 256; a++) mem[i][a] = v;
  endtask

  task automatic seq_const(input bit done);
    for (int c = 0; c < LIM; c++) begin run_seq[c] = 1'b1; done_seq[c] = done; end
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    logic [7:0] opc [4];
    opc[0] = 8'h90; opc[1] = 8'h91; opc[2] = 8'hC0; opc[3] = 8'hC1;
    if (r < 30) return opc[$urandom_range(0, 3)];
    if (r < 85) return 8'(8'h92 + $urandom_range(0, 23));
    if (r < 88) return 8'hFF;
    if (r < 90) return 8'h50;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // program: ALU op then HALT
    fill(0, 8'hFF); fill(1, 8'hFF);
    mem[0][0] = 8'h92; mem[0][1] = 8'hFF;
    seq_const(1'b1);
    run_test(-1);
    chk("t1 model halted@6", {tr[0][5].halted, tr[0][6].halted}, 2'b01);
    chk("t1 load1", {act[0][2].iirn, act[0][2].ir}, {1'b0, 8'h92});
    chk("t1 load2", {act[0][5].iirn, act[0][5].ir}, {1'b0, 8'hFF});
    chk("t1 halt pc", {act[0][6].halted, act[0][6].addr}, {1'b1, 8'h02});

    // LD_A with three stalled EXEC cycles
    fill(0, 8'hFF); fill(1, 8'hFF);
    mem[0][0] = 8'h90; mem[0][1] = 8'h5A;
    seq_const(1'b1);
    for (int c = 0; c < 8; c++) done_seq[c] = 1'b0;
    run_test(-1);
    cnt = 0;
    for (int c = 0; c < LIM; c++) cnt += int'(act[0][c].vld);
    chk("t2 vld cycles", cnt, 4);
    chk("t2 opnd", act[0][9].opnd, 8'h5A);
    chk("t2 next fetch", {act[0][9].rdn, act[0][9].addr}, {1'b0, 8'h02});
    chk("t2 model fetch@9", tr[0][9].addr, 8'h02);

    // JMP to a HALT
    fill(0, 8'hFF); fill(1, 8'hFF);
    mem[0][0] = 8'hC1; mem[0][1] = 8'h40; mem[0][8'h40] = 8'hFF;
    seq_const(1'b1);
    run_test(-1);
    chk("t3 addr seq", {act[0][1].addr, act[0][3].addr, act[0][5].addr}, 24'h000140);
    chk("t3 fetch target", act[0][5].rdn, 1'b0);
    cnt = 0;
    for (int c = 0; c < LIM; c++) cnt += int'(act[0][c].vld);
    chk("t3 no vld", cnt, 0);
    chk("t3 halted", act[0][LIM-1].halted, 1'b1);

    // PC wrap with PC_RESET=FE; inst0 sees illegal opcode 50
    fill(0, 8'hFF); fill(1, 8'hFF);
    mem[1][8'hFE] = 8'h91; mem[1][8'hFF] = 8'h33; mem[1][8'h00] = 8'hFF;
    mem[0][0] = 8'h50;
    seq_const(1'b1);
    run_test(-1);
    chk("t4 opnd", act[1][5].opnd, 8'h33);
    chk("t4 wrap fetch", {act[1][6].rdn, act[1][6].addr}, {1'b0, 8'h00});
    chk("t4 halt byte", {act[1][7].iirn, act[1][7].ir, act[1][8].halted, act[1][8].illegal},
        {1'b0, 8'hFF, 1'b1, 1'b0});
    chk("t5 illegal", {act[0][3].halted, act[0][3].illegal}, 2'b11);
    cnt = 0;
    for (int c = 0; c < LIM; c++) cnt += int'(!act[0][c].rdn);
    chk("t5 one read", cnt, 1);
    chk("t5 model illegal", tr[0][3].illegal, 1'b1);

    // asynchronous clear during OFETCH, then a clean restart
    fill(0, 8'hFF); fill(1, 8'hFF);
    mem[0][0] = 8'h90; mem[0][1] = 8'h5A;
    mem[1][8'hFE] = 8'hC0; mem[1][8'hFF] = 8'h77;
    seq_const(1'b1);
    run_test(3);
    run_test(-1);
    chk("t6 refetch", {act[0][1].rdn, act[0][1].addr, act[1][1].addr}, {1'b0, 8'h00, 8'hFE});

    // random programs, idle lead-in, RUN toggling and EXEC_DONE stalls
    for (int t = 0; t < 30; t++) begin
      int lead = $urandom_range(0, 3);
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 256; a++) mem[i][a] = rand_byte();
      for (int c = 0; c < LIM; c++) begin
        run_seq[c]  = (c < lead) ? 1'b0 : (c == lead) ? 1'b1 : 1'($urandom_range(0, 1));
        done_seq[c] = ($urandom_range(0, 2) != 0);
      end
      run_test(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
